pack_serializer_4to1: RTL

Upstream feeder for the 1-write/4-read FIFO. Accepts a 4-lane group with a per-lane valid mask on a valid/ready handshake. Emits the masked lanes one per cycle, lowest lane first, on a single valid/ready stream that connects directly to the FIFO write port. Zero-bubble between groups; all-zero masks are absorbed without output.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/lsb_pick4.sv | 41 ++++
 rtl/pack_serializer_4to1.sv | 93 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the 1-write/4-read FIFO and its feeders.
//   LANES        - lanes per group, fixed at 4
//   lane_mask_t  - per-lane valid mask
//   lane_idx_t   - lane index
//   hold_state_t - occupancy of a group holding register (EMPTY / HOLD)
package fifo_pkg;

    localparam int unsigned LANES = 4;

    typedef logic [LANES-1:0]         lane_mask_t;
    typedef logic [$clog2(LANES)-1:0] lane_idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/lsb_pick4.sv
// lsb_pick4: combinational lowest-set-bit picker for a 4-bit lane mask.
// Ports:
//   mask   in   4-bit lane mask
//   idx    out  index of the lowest set bit (0 when mask is zero)
//   any    out  at least one bit set
//   clr    out  one-hot vector of the picked bit (zero when mask is zero)
//   single out  exactly one bit set
module lsb_pick4
    import fifo_pkg::*;
(
    input  lane_mask_t mask,
    output lane_idx_t  idx,
    output logic       any,
    output lane_mask_t clr,
    output logic       single
);

    always_comb begin
        idx = '0;
        clr = '0;
        if (mask[0]) begin
            idx = 2'd0;
            clr = 4'b0001;
        end else if (mask[1]) begin
            idx = 2'd1;
            clr = 4'b0010;
        end else if (mask[2]) begin
            idx = 2'd2;
            clr = 4'b0100;
        end else if (mask[3]) begin
            idx = 2'd3;
            clr = 4'b1000;
        end
    end

    assign any = |mask;

    // Clearing the lowest set bit leaves nothing exactly when one bit was set.
    assign single = any && ((mask & ~clr) == '0);

endmodule

// File: rtl/pack_serializer_4to1.sv
// pack_serializer_4to1: accepts a 4-lane group with a per-lane valid mask and
// emits the masked lanes one per cycle, lowest lane first. Next group is
// accepted on the edge that fires the last element (no bubble); all-zero
// masks are absorbed without producing output.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   valid_in   in   group present on data_in / mask_in
//   ready_in   out  group accepted when valid_in && ready_in
//   data_in    in   WIDTH x LANES elements, lane 0..3
//   mask_in    in   bit i set = lane i carries an element
//   valid_out  out  element present on data_out
//   ready_out  in   downstream can take an element
//   data_out   out  current element
//   lane_out   out  source lane of data_out
//   last_out   out  data_out is the final remaining element of its group
module pack_serializer_4to1
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = fifo_pkg::LANES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] data_in [LANES],
    input  lane_mask_t       mask_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] data_out,
    output lane_idx_t        lane_out,
    output logic             last_out
);

    if (LANES != 4) begin : g_lanes_check
        $error("pack_serializer_4to1: LANES must be 4");
    end

    logic [WIDTH-1:0] hold_data [LANES];
    lane_mask_t       hold_mask;

    lane_idx_t        pick_idx;
    logic             pick_any;
    lane_mask_t       pick_clr;
    logic             pick_single;

    hold_state_t      state;
    logic             fire;
    logic             accept;

    lsb_pick4 u_pick (
        .mask   (hold_mask),
        .idx    (pick_idx),
        .any    (pick_any),
        .clr    (pick_clr),
        .single (pick_single)
    );

    // Occupancy is derived from the mask itself; there is no state register.
    assign state = pick_any ? ST_HOLD : ST_EMPTY;

    assign valid_out = (state == ST_HOLD);
    assign data_out  = pick_any ? hold_data[pick_idx] : '0;
    assign lane_out  = pick_any ? pick_idx : '0;
    assign last_out  = pick_single;

    assign fire = valid_out && ready_out;

    // Combinational from ready_out: the next group loads on the same edge
    // that retires the last element, so output never idles between groups.
    assign ready_in = ~reset && ((state == ST_EMPTY) || (fire && last_out));
    assign accept   = valid_in && ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_mask <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                hold_data[i] <= '0;
            end
        end else if (accept) begin
            // Load wins over the fire-clear; the only overlap is on the last
            // element, whose clear would leave zero anyway.
            hold_mask <= mask_in;
            for (int unsigned i = 0; i < LANES; i++) begin
                hold_data[i] <= data_in[i];
            end
        end else if (fire) begin
            hold_mask <= hold_mask & ~pick_clr;
        end
    end

endmodule
